rob_commit_unit: RTL and testbench

Retirement stage directly downstream of the reorder buffer. Watches the ROB head (instr word, value, ready) and retires completed entries in program order. Drives register-file writeback and releases committed stores to the store buffer via a request/ack handshake. On a mispredicted branch it flushes younger ROB entries and redirects fetch.

---
 rtl/rob_commit_pkg.sv | 34 +++
 rtl/commit_decode.sv | 39 +++
 rtl/rob_commit_unit.sv | 161 ++++++++++++++++
 tb/tb_rob_commit_unit.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rob_commit_pkg.sv
// Shared opcodes, instruction classes and FSM encodings for the ROB commit stage.
package rob_commit_pkg;

   localparam int unsigned OPC_W = 5;
   localparam int unsigned RID_W = 5;

   localparam logic [OPC_W-1:0] OP_ALU  = 5'b00000;
   localparam logic [OPC_W-1:0] OP_J    = 5'b00001;
   localparam logic [OPC_W-1:0] OP_BNE  = 5'b00010;
   localparam logic [OPC_W-1:0] OP_JAL  = 5'b00011;
   localparam logic [OPC_W-1:0] OP_JR   = 5'b00100;
   localparam logic [OPC_W-1:0] OP_ADDI = 5'b00101;
   localparam logic [OPC_W-1:0] OP_BLT  = 5'b00110;
   localparam logic [OPC_W-1:0] OP_SW   = 5'b00111;
   localparam logic [OPC_W-1:0] OP_LW   = 5'b01000;
   localparam logic [OPC_W-1:0] OP_SETX = 5'b10101;

   localparam logic [RID_W-1:0] RA_REG     = 5'd31;
   localparam logic [RID_W-1:0] STATUS_REG = 5'd30;

   typedef enum logic [1:0] {
      CL_BUBBLE,
      CL_WB,
      CL_STORE,
      CL_BRANCH
   } instr_class_t;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ST_WAIT,
      S_FLUSH
   } state_t;

endpackage

// File: rtl/commit_decode.sv
// Classifies the ROB head instruction and resolves its effective destination register.
module commit_decode
   import rob_commit_pkg::*;
#(
   parameter int unsigned XLEN     = 32,
   parameter int unsigned REG_BITS = 5
) (
   input  logic [XLEN-1:0]     i_instr,
   output instr_class_t        o_class,
   output logic [REG_BITS-1:0] o_rd
);

   logic [OPC_W-1:0] w_opc;

   assign w_opc = i_instr[31:27];

   always_comb begin
      o_class = CL_BUBBLE;
      o_rd    = REG_BITS'(i_instr[26:22]);
      // An all-zero word is a bubble regardless of what its opcode field decodes to
      if (i_instr != '0) begin
         case (w_opc)
            OP_ALU, OP_ADDI, OP_LW: o_class = CL_WB;
            OP_SETX: begin
               o_class = CL_WB;
               o_rd    = REG_BITS'(STATUS_REG);
            end
            OP_JAL: begin
               o_class = CL_WB;
               o_rd    = REG_BITS'(RA_REG);
            end
            OP_SW:                        o_class = CL_STORE;
            OP_BNE, OP_BLT, OP_J, OP_JR:  o_class = CL_BRANCH;
            default:                      o_class = CL_BUBBLE;
         endcase
      end
   end

endmodule

// File: rtl/rob_commit_unit.sv
// In-order retirement: register writeback, store release handshake, and
// mispredict flush/redirect for the entry at the ROB head.
module rob_commit_unit
   import rob_commit_pkg::*;
#(
   parameter int unsigned XLEN     = 32,
   parameter int unsigned REG_BITS = 5,
   parameter int unsigned CNT_W    = 32
) (
   input  logic                clock,
   input  logic                reset,
   input  logic [XLEN-1:0]     rob_head_instr,
   input  logic [XLEN-1:0]     rob_head_val,
   input  logic                rob_head_ready,
   input  logic                rob_is_empty,
   output logic                rob_pop,
   output logic                rob_flush,
   output logic [XLEN-1:0]     rob_flush_instr,
   output logic                rf_wEn,
   output logic [REG_BITS-1:0] rf_waddr,
   output logic [XLEN-1:0]     rf_wdata,
   output logic                st_commit,
   output logic [XLEN-1:0]     st_tag,
   input  logic                st_ack,
   output logic                redirect,
   output logic [XLEN-1:0]     redirect_pc,
   output logic [CNT_W-1:0]    retired_count
);

   state_t                r_state;
   state_t                w_state_nxt;
   instr_class_t          w_class;
   logic [REG_BITS-1:0]   w_rd;
   logic                  w_commit_ok;
   logic                  w_pop;
   logic                  w_flush;
   logic                  w_wb;
   logic                  w_st_start;
   logic                  w_st_done;
   logic                  w_redir;

   logic                  r_rf_wen;
   logic [REG_BITS-1:0]   r_rf_waddr;
   logic [XLEN-1:0]       r_rf_wdata;
   logic                  r_st_commit;
   logic [XLEN-1:0]       r_st_tag;
   logic                  r_redirect;
   logic [XLEN-1:0]       r_redirect_pc;
   logic [CNT_W-1:0]      r_retired_count;

   commit_decode #(
      .XLEN     (XLEN),
      .REG_BITS (REG_BITS)
   ) u_decode (
      .i_instr (rob_head_instr),
      .o_class (w_class),
      .o_rd    (w_rd)
   );

   assign w_commit_ok = !rob_is_empty && rob_head_ready;

   // Next state and per-cycle retire decisions
   always_comb begin
      w_state_nxt = r_state;
      w_pop       = 1'b0;
      w_flush     = 1'b0;
      w_wb        = 1'b0;
      w_st_start  = 1'b0;
      w_st_done   = 1'b0;
      w_redir     = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_commit_ok) begin
               case (w_class)
                  CL_STORE: begin
                     w_st_start  = 1'b1;
                     w_state_nxt = S_ST_WAIT;
                  end
                  CL_BRANCH: begin
                     if (rob_head_val[0]) begin
                        w_flush     = 1'b1;
                        w_state_nxt = S_FLUSH;
                     end else begin
                        w_pop = 1'b1;
                     end
                  end
                  CL_WB: begin
                     w_pop = 1'b1;
                     w_wb  = (w_rd != '0);
                  end
                  default: w_pop = 1'b1;
               endcase
            end
         end
         S_ST_WAIT: begin
            if (w_commit_ok && st_ack) begin
               w_pop       = 1'b1;
               w_st_done   = 1'b1;
               w_state_nxt = S_IDLE;
            end
         end
         S_FLUSH: begin
            if (w_commit_ok) begin
               w_pop       = 1'b1;
               w_redir     = 1'b1;
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Combinational ROB controls are held off while reset is asserted
   assign rob_pop         = w_pop && reset;
   assign rob_flush       = w_flush && reset;
   assign rob_flush_instr = (w_flush && reset) ? rob_head_instr : '0;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state         <= S_IDLE;
         r_rf_wen        <= 1'b0;
         r_rf_waddr      <= '0;
         r_rf_wdata      <= '0;
         r_st_commit     <= 1'b0;
         r_st_tag        <= '0;
         r_redirect      <= 1'b0;
         r_redirect_pc   <= '0;
         r_retired_count <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_rf_wen   <= w_wb;
         r_redirect <= w_redir;
         if (w_wb) begin
            r_rf_waddr <= w_rd;
            r_rf_wdata <= rob_head_val;
         end
         if (w_st_start) begin
            r_st_commit <= 1'b1;
            r_st_tag    <= rob_head_instr;
         end else if (w_st_done) begin
            r_st_commit <= 1'b0;
         end
         if (w_redir) begin
            r_redirect_pc <= {rob_head_val[XLEN-1:1], 1'b0};
         end
         if (w_pop && (rob_head_instr != '0)) begin
            r_retired_count <= r_retired_count + CNT_W'(1);
         end
      end
   end

   assign rf_wEn        = r_rf_wen;
   assign rf_waddr      = r_rf_waddr;
   assign rf_wdata      = r_rf_wdata;
   assign st_commit     = r_st_commit;
   assign st_tag        = r_st_tag;
   assign redirect      = r_redirect;
   assign redirect_pc   = r_redirect_pc;
   assign retired_count = r_retired_count;

endmodule

// File: tb/tb_rob_commit_unit.sv
// Randomized and directed checks of rob_commit_unit against an in-bench retirement model.
module tb_rob_commit_unit;

   logic        clock = 1'b0;
   logic        reset;
   logic [31:0] rob_head_instr;
   logic [31:0] rob_head_val;
   logic        rob_head_ready;
   logic        rob_is_empty;
   logic        rob_pop;
   logic        rob_flush;
   logic [31:0] rob_flush_instr;
   logic        rf_wEn;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;
   logic        st_commit;
   logic [31:0] st_tag;
   logic        st_ack;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic [31:0] retired_count;

   rob_commit_unit #(.XLEN(32), .REG_BITS(5), .CNT_W(32)) dut (
      .clock           (clock),
      .reset           (reset),
      .rob_head_instr  (rob_head_instr),
      .rob_head_val    (rob_head_val),
      .rob_head_ready  (rob_head_ready),
      .rob_is_empty    (rob_is_empty),
      .rob_pop         (rob_pop),
      .rob_flush       (rob_flush),
      .rob_flush_instr (rob_flush_instr),
      .rf_wEn          (rf_wEn),
      .rf_waddr        (rf_waddr),
      .rf_wdata        (rf_wdata),
      .st_commit       (st_commit),
      .st_tag          (st_tag),
      .st_ack          (st_ack),
      .redirect        (redirect),
      .redirect_pc     (redirect_pc),
      .retired_count   (retired_count)
   );

   always #5 clock = ~clock;

   int n_tests = 0;
   int n_fail  = 0;

   // Model state: which handshake the retire stage is waiting on, and the
   // registered outputs the previous cycle's retire should have produced.
   bit          m_wait_st = 0;
   bit          m_wait_fl = 0;
   logic        e_wen = 0, e_st = 0, e_redir = 0;
   logic [4:0]  e_waddr = '0;
   logic [31:0] e_wdata = '0, e_tag = '0, e_rpc = '0, e_cnt = '0;
   logic        s_pop, s_flush;

   logic [31:0] q_instr[$];
   logic [31:0] q_val[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // 0 = no effect, 1 = writeback, 2 = store, 3 = branch
   function automatic int kind_of(input logic [31:0] w);
      logic [4:0] op;
      op = w[31:27];
      if (w == 32'h0) return 0;
      case (op)
         5'b00000, 5'b00101, 5'b01000, 5'b10101, 5'b00011: return 1;
         5'b00111:                                         return 2;
         5'b00010, 5'b00110, 5'b00001, 5'b00100:           return 3;
         default:                                          return 0;
      endcase
   endfunction

   function automatic logic [4:0] rd_of(input logic [31:0] w);
      logic [4:0] op;
      op = w[31:27];
      if (op == 5'b10101) return 5'd30;
      if (op == 5'b00011) return 5'd31;
      return w[26:22];
   endfunction

   // One clock: drive head, check combinational outputs, cross the edge, check registered outputs
   task automatic cycle(input logic [31:0] instr, input logic [31:0] val,
                        input logic rdy, input logic emp, input logic ack,
                        output logic o_pop, output logic o_fl);
      logic ok, pop, fl, idle, nwen, st_start, st_end, redir;
      int   kind;
      logic [4:0] rd;
      rob_head_instr = instr;
      rob_head_val   = val;
      rob_head_ready = rdy;
      rob_is_empty   = emp;
      st_ack         = ack;
      #1;
      kind = kind_of(instr);
      rd   = rd_of(instr);
      ok   = !emp && rdy;
      idle = !m_wait_st && !m_wait_fl;
      pop  = 1'b0;
      fl   = 1'b0;
      if (m_wait_st)      pop = ok && ack;
      else if (m_wait_fl) pop = ok;
      else if (ok) begin
         if (kind == 2)                 pop = 1'b0;
         else if (kind == 3 && val[0])  fl  = 1'b1;
         else                           pop = 1'b1;
      end
      chk("rob_pop", 32'(rob_pop), 32'(pop));
      chk("rob_flush", 32'(rob_flush), 32'(fl));
      if (fl) chk("rob_flush_instr", rob_flush_instr, instr);
      s_pop   = rob_pop;
      s_flush = rob_flush;
      nwen     = idle && pop && kind == 1 && rd != 5'd0;
      st_start = idle && ok && kind == 2;
      st_end   = m_wait_st && pop;
      redir    = m_wait_fl && pop;
      @(posedge clock);
      #1;
      e_wen = nwen;
      if (nwen) begin
         e_waddr = rd;
         e_wdata = val;
      end
      if (st_start) begin
         e_st = 1'b1;
         e_tag = instr;
         m_wait_st = 1;
      end else if (st_end) begin
         e_st = 1'b0;
         m_wait_st = 0;
      end
      if (fl) m_wait_fl = 1;
      if (redir) begin
         m_wait_fl = 0;
         e_rpc = {val[31:1], 1'b0};
      end
      e_redir = redir;
      if (pop && instr != 32'h0) e_cnt = e_cnt + 32'd1;
      chk("rf_wEn", 32'(rf_wEn), 32'(e_wen));
      if (e_wen) begin
         chk("rf_waddr", 32'(rf_waddr), 32'(e_waddr));
         chk("rf_wdata", rf_wdata, e_wdata);
      end
      chk("st_commit", 32'(st_commit), 32'(e_st));
      if (e_st) chk("st_tag", st_tag, e_tag);
      chk("redirect", 32'(redirect), 32'(e_redir));
      if (e_redir) chk("redirect_pc", redirect_pc, e_rpc);
      chk("retired_count", retired_count, e_cnt);
      o_pop = pop;
      o_fl  = fl;
   endtask

   function automatic logic [31:0] rand_instr();
      logic [4:0]  ops[10];
      logic [31:0] w;
      int          r;
      ops = '{5'b00000, 5'b00101, 5'b01000, 5'b10101, 5'b00011,
              5'b00111, 5'b00010, 5'b00110, 5'b00001, 5'b00100};
      r = $urandom_range(10);
      if (r == 10) return 32'h0;
      w = $urandom;
      w[31:27] = ops[r];
      return w;
   endfunction

   logic        p, f;
   logic [31:0] w_add, w_addi, w_sw, w_bne, w_addi0, hi, hv;

   initial begin
      reset          = 1'b0;
      rob_head_instr = '0;
      rob_head_val   = '0;
      rob_head_ready = 1'b0;
      rob_is_empty   = 1'b1;
      st_ack         = 1'b0;
      @(posedge clock);
      @(posedge clock);
      #1;
      chk("reset_pop", 32'(rob_pop), 32'd0);
      chk("reset_wen", 32'(rf_wEn), 32'd0);
      chk("reset_st", 32'(st_commit), 32'd0);
      chk("reset_redirect", 32'(redirect), 32'd0);
      chk("reset_count", retired_count, 32'd0);
      @(negedge clock);
      reset = 1'b1;
      @(posedge clock);
      #1;

      // add r5 with one-cycle writeback latency
      w_add = 32'h0140_0000;
      cycle(w_add, 32'h1234, 1, 0, 0, p, f);
      chk("t1_pop", 32'(s_pop), 32'd1);
      chk("t1_wen", 32'(rf_wEn), 32'd1);
      chk("t1_waddr", 32'(rf_waddr), 32'd5);
      chk("t1_wdata", rf_wdata, 32'h1234);
      chk("t1_count", retired_count, 32'd1);

      // head not ready for three cycles
      w_addi = {5'b00101, 5'd7, 22'h0};
      for (int i = 0; i < 3; i++) begin
         cycle(w_addi, 32'h77, 0, 0, 0, p, f);
         chk("t2_nopop", 32'(s_pop), 32'd0);
         chk("t2_nowen", 32'(rf_wEn), 32'd0);
      end
      cycle(w_addi, 32'h77, 1, 0, 0, p, f);
      chk("t2_pop", 32'(s_pop), 32'd1);
      chk("t2_waddr", 32'(rf_waddr), 32'd7);

      // store released only on ack
      w_sw = {5'b00111, 5'd3, 22'h00abc};
      cycle(w_sw, 32'h0, 1, 0, 0, p, f);
      chk("t3_nopop0", 32'(s_pop), 32'd0);
      for (int i = 0; i < 3; i++) begin
         chk("t3_st_held", 32'(st_commit), 32'd1);
         chk("t3_tag_held", st_tag, w_sw);
         cycle(w_sw, 32'h0, 1, 0, 0, p, f);
         chk("t3_nopop", 32'(s_pop), 32'd0);
      end
      chk("t3_st_last", 32'(st_commit), 32'd1);
      cycle(w_sw, 32'h0, 1, 0, 1, p, f);
      chk("t3_ack_pop", 32'(s_pop), 32'd1);
      chk("t3_st_drop", 32'(st_commit), 32'd0);
      chk("t3_count", retired_count, 32'd3);

      // mispredicted bne: flush, pop, redirect
      w_bne = {5'b00010, 5'd0, 22'h1};
      cycle(w_bne, 32'h401, 1, 0, 0, p, f);
      chk("t4_flush", 32'(s_flush), 32'd1);
      chk("t4_flush_pop", 32'(s_pop), 32'd0);
      cycle(w_bne, 32'h401, 1, 0, 0, p, f);
      chk("t4_pop", 32'(s_pop), 32'd1);
      chk("t4_redirect", 32'(redirect), 32'd1);
      chk("t4_redirect_pc", redirect_pc, 32'h400);
      cycle(32'h0, 32'h0, 0, 1, 0, p, f);
      chk("t4_redirect_once", 32'(redirect), 32'd0);

      // bubble pops without counting; addi r0 counts without writing
      cycle(32'h0, 32'h55, 1, 0, 0, p, f);
      chk("t5_bubble_pop", 32'(s_pop), 32'd1);
      chk("t5_bubble_wen", 32'(rf_wEn), 32'd0);
      chk("t5_bubble_cnt", retired_count, 32'd4);
      w_addi0 = {5'b00101, 5'd0, 22'h3};
      cycle(w_addi0, 32'h66, 1, 0, 0, p, f);
      chk("t5_r0_wen", 32'(rf_wEn), 32'd0);
      chk("t5_r0_cnt", retired_count, 32'd5);

      // reset in the middle of a store handshake
      cycle(w_sw, 32'h0, 1, 0, 0, p, f);
      cycle(w_sw, 32'h0, 1, 0, 0, p, f);
      st_ack = 1'b1;
      #2;
      reset = 1'b0;
      #1;
      chk("t6_st_drop", 32'(st_commit), 32'd0);
      chk("t6_count", retired_count, 32'd0);
      chk("t6_nopop", 32'(rob_pop), 32'd0);
      m_wait_st = 0; m_wait_fl = 0;
      e_wen = 0; e_st = 0; e_redir = 0; e_cnt = '0;
      @(posedge clock);
      @(negedge clock);
      reset = 1'b1;
      @(posedge clock);
      #1;
      cycle(w_sw, 32'h0, 1, 0, 0, p, f);
      chk("t6_recommit", 32'(st_commit), 32'd1);
      chk("t6_retag", st_tag, w_sw);
      cycle(w_sw, 32'h0, 1, 0, 1, p, f);
      chk("t6_count_after", retired_count, 32'd1);

      // random instruction streams through a modelled ROB
      for (int c = 0; c < 4000; c++) begin
         if (!m_wait_fl && q_instr.size() < 3 && $urandom_range(3) != 0) begin
            q_instr.push_back(rand_instr());
            q_val.push_back($urandom);
         end
         hi = (q_instr.size() != 0) ? q_instr[0] : 32'h0;
         hv = (q_val.size() != 0) ? q_val[0] : 32'h0;
         cycle(hi, hv, 1'($urandom_range(3) != 0), 1'(q_instr.size() == 0),
               1'($urandom_range(2) == 0), p, f);
         if (f) begin
            while (q_instr.size() > 1) begin
               void'(q_instr.pop_back());
               void'(q_val.pop_back());
            end
         end
         if (p) begin
            void'(q_instr.pop_front());
            void'(q_val.pop_front());
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
